// File: rtl/link_tx_sequencer.sv
// link_tx_sequencer: symbol sequencer in front of an 8b/10b encoder.
// After reset it sends SYNC_LEN K28.5 commas, then idle fill (K28.0) with
// one comma every COMMA_PERIOD idle symbols. Frames from two byte-stream
// requesters are granted round-robin and framed as SOF, data, EOF.
//
// Optional feature macro: TXSEQ_MAXLEN_EN
//   defined   : frames longer than MAX_LEN bytes are cut with ERR (K30.7);
//               the rest of the frame is drained and discarded, then EOF.
//   undefined : frame length is unbounded.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   enb       global enable; 0 freezes the block
//   in_valid  per-requester byte valid (bit p = requester p)
//   in_data0  requester 0 byte
//   in_data1  requester 1 byte
//   in_last   per-requester last byte of frame
//   in_ready  per-requester ready (combinational)
//   enc_data  byte to encoder (registered)
//   enc_k     K-symbol flag to encoder (registered)
//   enc_enb   encoder enable (registered)
//   link_up   sync phase complete (registered)
//   busy      framing in progress (registered)
module link_tx_sequencer #(
  parameter int unsigned SYNC_LEN     = 16,
  parameter int unsigned COMMA_PERIOD = 8,
  parameter int unsigned MAX_LEN      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [1:0] in_valid,
  input  logic [7:0] in_data0,
  input  logic [7:0] in_data1,
  input  logic [1:0] in_last,
  output logic [1:0] in_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       enc_enb,
  output logic       link_up,
  output logic       busy
);

  localparam int unsigned SyncW = $clog2(SYNC_LEN + 1);
  localparam int unsigned IdleW = $clog2(COMMA_PERIOD);

  localparam logic [7:0] SymComma = 8'hBC;  // K28.5
  localparam logic [7:0] SymFill  = 8'h1C;  // K28.0
  localparam logic [7:0] SymSof   = 8'hFB;  // K27.7
  localparam logic [7:0] SymEof   = 8'hFD;  // K29.7
`ifdef TXSEQ_MAXLEN_EN
  localparam logic [7:0] SymErr   = 8'hFE;  // K30.7
  localparam int unsigned LenW    = $clog2(MAX_LEN + 1);
`endif

  // Reject parameter values the counters cannot represent.
  if (SYNC_LEN < 1 || COMMA_PERIOD < 2 || MAX_LEN < 1) begin : g_bad_params
    $error("link_tx_sequencer: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_IDLE = 3'd1,
    S_DATA = 3'd2,
    S_EOF  = 3'd3,
    S_DROP = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [SyncW-1:0] sync_cnt_q, sync_cnt_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic             gap_q, gap_d;        // force one idle symbol after EOF
  logic [7:0]       enc_data_q, enc_data_d;
  logic             enc_k_q, enc_k_d;
  logic             enc_enb_q, enc_enb_d;
  logic             link_up_q, link_up_d;
  logic             busy_q, busy_d;
`ifdef TXSEQ_MAXLEN_EN
  logic [LenW-1:0]  byte_cnt_q, byte_cnt_d;
  logic             len_hit_c;
`endif

  // Granted requester's stream, muxed once for the DATA/DROP states.
  logic       valid_g_c;
  logic       last_g_c;
  logic [7:0] data_g_c;
  logic       accept_c;

  assign valid_g_c = grant_q ? in_valid[1] : in_valid[0];
  assign last_g_c  = grant_q ? in_last[1]  : in_last[0];
  assign data_g_c  = grant_q ? in_data1    : in_data0;

`ifdef TXSEQ_MAXLEN_EN
  // MAX_LEN bytes already sent: the next symbol is ERR, so nothing is taken.
  assign len_hit_c = (byte_cnt_q == LenW'(MAX_LEN));
  assign accept_c  = enb && ((state_q == S_DATA && !len_hit_c) || state_q == S_DROP);
`else
  assign accept_c  = enb && (state_q == S_DATA);
`endif

  // Ready only toward the granted requester while a frame accepts bytes.
  always_comb begin : ready_comb
    in_ready = 2'b00;
    if (accept_c) begin
      in_ready = grant_q ? 2'b10 : 2'b01;
    end
  end

  // Next-state and next-output logic.
  always_comb begin : next_comb
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    gap_d        = gap_q;
    enc_data_d   = enc_data_q;
    enc_k_d      = enc_k_q;
    enc_enb_d    = 1'b0;
    link_up_d    = link_up_q;
    busy_d       = busy_q;
`ifdef TXSEQ_MAXLEN_EN
    byte_cnt_d   = byte_cnt_q;
`endif

    if (enb) begin
      enc_enb_d = 1'b1;
      case (state_q)
        S_SYNC: begin
          enc_data_d = SymComma;
          enc_k_d    = 1'b1;
          sync_cnt_d = sync_cnt_q + SyncW'(1);
          if (sync_cnt_q == SyncW'(SYNC_LEN - 1)) begin
            state_d   = S_IDLE;
            link_up_d = 1'b1;
          end
        end

        S_IDLE: begin
          if (idle_cnt_q == IdleW'(COMMA_PERIOD - 1)) begin
            // Periodic comma wins over a pending request.
            enc_data_d = SymComma;
            enc_k_d    = 1'b1;
            idle_cnt_d = '0;
            gap_d      = 1'b0;
          end else if (in_valid != 2'b00 && !gap_q) begin
            // Single requester wins outright; on a tie the other one than last time.
            grant_d      = (in_valid == 2'b11) ? ~last_grant_q : in_valid[1];
            last_grant_d = grant_d;
            enc_data_d   = SymSof;
            enc_k_d      = 1'b1;
            busy_d       = 1'b1;
            state_d      = S_DATA;
`ifdef TXSEQ_MAXLEN_EN
            byte_cnt_d   = '0;
`endif
          end else begin
            enc_data_d = SymFill;
            enc_k_d    = 1'b1;
            idle_cnt_d = idle_cnt_q + IdleW'(1);
            gap_d      = 1'b0;
          end
        end

        S_DATA: begin
`ifdef TXSEQ_MAXLEN_EN
          if (len_hit_c) begin
            enc_data_d = SymErr;
            enc_k_d    = 1'b1;
            state_d    = S_DROP;
          end else
`endif
          if (valid_g_c) begin
            enc_data_d = data_g_c;
            enc_k_d    = 1'b0;
`ifdef TXSEQ_MAXLEN_EN
            byte_cnt_d = byte_cnt_q + LenW'(1);
`endif
            if (last_g_c) begin
              state_d = S_EOF;
            end
          end else begin
            // Requester stalled: keep the frame open with fill.
            enc_data_d = SymFill;
            enc_k_d    = 1'b1;
          end
        end

`ifdef TXSEQ_MAXLEN_EN
        S_DROP: begin
          // Drain the oversized frame; its bytes never reach the encoder.
          enc_data_d = SymFill;
          enc_k_d    = 1'b1;
          if (valid_g_c && last_g_c) begin
            state_d = S_EOF;
          end
        end
`endif

        S_EOF: begin
          enc_data_d = SymEof;
          enc_k_d    = 1'b1;
          busy_d     = 1'b0;
          gap_d      = 1'b1;
          state_d    = S_IDLE;
        end

        default: begin
          state_d = S_SYNC;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin : regs
    if (!rst) begin
      state_q      <= S_SYNC;
      sync_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      gap_q        <= 1'b0;
      enc_data_q   <= SymComma;
      enc_k_q      <= 1'b1;
      enc_enb_q    <= 1'b0;
      link_up_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef TXSEQ_MAXLEN_EN
      byte_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      gap_q        <= gap_d;
      enc_data_q   <= enc_data_d;
      enc_k_q      <= enc_k_d;
      enc_enb_q    <= enc_enb_d;
      link_up_q    <= link_up_d;
      busy_q       <= busy_d;
`ifdef TXSEQ_MAXLEN_EN
      byte_cnt_q   <= byte_cnt_d;
`endif
    end
  end

  assign enc_data = enc_data_q;
  assign enc_k    = enc_k_q;
  assign enc_enb  = enc_enb_q;
  assign link_up  = link_up_q;
  assign busy     = busy_q;

endmodule

// File: doc/link_tx_sequencer.md
Name: link_tx_sequencer

Overview:
Controller that sequences the 8b/10b encoder's byte/K inputs. After reset it runs a link-sync phase of K28.5 commas, then emits idle fill with periodic commas. It frames payload from two byte-stream requesters, arbitrated round-robin, as SOF, data bytes, then EOF. It sits directly in front of the encoder; its registered outputs drive the encoder's data, K and enable inputs.

Parameters:
SYNC_LEN, 16, number of K28.5 symbols sent after reset before the link is up (minimum 1).
COMMA_PERIOD, 8, one K28.5 replaces idle fill every COMMA_PERIOD consecutive idle symbols (minimum 2).
MAX_LEN, 64, maximum payload bytes per frame; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (asserted at 0).
enb  in  1  global enable; 0 freezes the block.
in_valid  in  2  per-requester byte valid; bit p belongs to requester p.
in_data0  in  8  requester 0 byte.
in_data1  in  8  requester 1 byte.
in_last  in  2  per-requester last byte of frame.
in_ready  out  2  per-requester ready; combinational.
enc_data  out  8  byte to the encoder; registered.
enc_k  out  1  K-symbol flag to the encoder; registered.
enc_enb  out  1  encoder enable; registered.
link_up  out  1  high once the sync phase is done; registered.
busy  out  1  high while in SOF, DATA or EOF; registered.

Behaviour:
- Symbol codes (K=1): COMMA K28.5 = 8'hBC; FILL K28.0 = 8'h1C; SOF K27.7 = 8'hFB; EOF K29.7 = 8'hFD; ERR K30.7 = 8'hFE. Data bytes are sent with K=0.
- Reset (rst=0, async): state SYNC, sync_cnt=0, idle_cnt=0, last_grant=1 (so port 0 wins first), enc_data=8'hBC, enc_k=1, enc_enb=0, link_up=0, busy=0, in_ready=0.
- enb=0: no state or counter change, in_ready=0, enc_enb<=0, enc_data and enc_k hold. When enb returns to 1, operation resumes at the same point.
- All remaining rules assume enb=1. Each rule gives the symbol registered at the next clk edge; enc_enb<=1.
- SYNC: emit COMMA and increment sync_cnt. After SYNC_LEN commas, go to IDLE and set link_up<=1 on the same edge as the last comma. link_up stays 1 until reset.
- IDLE:
  - If idle_cnt==COMMA_PERIOD-1: emit COMMA, set idle_cnt=0, and defer any request by one cycle (comma has priority).
  - Else if any in_valid bit is set: arbitrate, emit SOF, latch grant, go to DATA, busy<=1. idle_cnt does not change while framing.
  - Else: emit FILL and increment idle_cnt.
- Arbitration: if only one port is valid, grant it. If both are valid, grant the port != last_grant. last_grant updates at SOF.
- DATA:
  - in_ready[g]=1 and in_ready for the other port=0.
  - On in_valid[g]: emit in_data of port g with K=0. If in_last[g], go to EOF.
  - If !in_valid[g]: emit FILL inside the frame (the frame stays open).
- EOF: emit EOF, go to IDLE, busy<=0. The following symbol is always an IDLE-state symbol, so there is at least one fill or comma between frames.
- in_ready is 0 in every state except DATA.
- Latency: a byte accepted at edge n appears on enc_data after edge n. The SOF for a request first seen at edge n is registered at edge n unless a comma is due.
- Reset asserted mid-frame aborts the frame immediately; there is no EOF and the sequencer restarts at SYNC.

Optional Feature:
TXSEQ_MAXLEN_EN
- Defined: a byte counter runs in DATA. If MAX_LEN bytes have been sent without in_last, the next symbol is ERR in place of data, and the block moves to state DROP. In DROP, in_ready[g]=1, accepted bytes are discarded and FILL is emitted. When in_last is accepted, the block moves to EOF.
- Not defined: there is no counter, no ERR and no DROP; frame length is unbounded.

Test Plan:
1. Hold rst=0 for 3 cycles, then release with enb=1 -> 16 cycles of enc_data=BC/k=1, then link_up=1, then 7 x 1C followed by BC, repeating.
2. Port 0 sends 3 bytes 11,22,33 (last on 33) -> enc stream FB, 11, 22, 33 (k=0), FD, then 1C; busy is high from the FB edge through the FD edge.
3. Both ports valid continuously, 2-byte frames each -> frames alternate 0, 1, 0, 1 with one idle symbol between each; first grant is port 0.
4. Port 1 drops in_valid for 2 cycles mid-frame -> two 1C symbols inside the frame, and the frame completes with the correct bytes.
5. enb=0 for 4 cycles mid-frame -> enc_enb=0, enc_data holds, in_ready=0; the stream continues unchanged afterwards.
6. With TXSEQ_MAXLEN_EN and MAX_LEN=4, send a 6-byte frame -> FB, 4 data bytes, FE, fill while bytes 5 and 6 are dropped, then FD.
